// File: rtl/prm_chk_pkg.sv
// Shared types for the PRM obstacle-logic check engine: FSM state, cube entry
// layout and the index/count widths of the cube store.
package prm_chk_pkg;

    localparam int CUBE_W     = 15;
    localparam int MAX_N_CUBE = 256;
    localparam int IDX_W_MAX  = $clog2(MAX_N_CUBE);
    localparam int CNT_W_MAX  = IDX_W_MAX + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } chk_state_t;

    typedef struct packed {
        logic [CUBE_W-1:0] care;
        logic [CUBE_W-1:0] val;
    } cube_t;

    // Select-field width that stays legal for a single-entry dimension.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prm_cube_match.sv
// Single-cube match: the query satisfies the cube when every cared literal
// has the required polarity. An all-zero care mask always matches.
module prm_cube_match #(
    parameter int W = 15
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] care,
    input  logic [W-1:0] val,
    output logic         match
);

    assign match = ~|((q ^ val) & care);

endmodule

// File: rtl/prm_oblgc_chk_engine.sv
// PRM edge collision checker: per-edge sum-of-products obstacle logic scanned
// one cube index per cycle across all edges. Optional PRM_CHK_EARLY_EXIT_EN
// ends the scan once every populated edge is already blocked.
//
//  state | meaning
//  IDLE  | accept queries and configuration writes
//  EVAL  | scan cube index 0..MAXC-1, all edges in parallel
//  DONE  | hold result until r_ready
module prm_oblgc_chk_engine
    import prm_chk_pkg::*;
#(
    parameter  int IN_W   = CUBE_W,
    parameter  int N_EDGE = 8,
    parameter  int N_CUBE = MAX_N_CUBE,
    localparam int EDGE_W = sel_w(N_EDGE),
    localparam int IDX_W  = sel_w(N_CUBE),
    localparam int CNT_W  = IDX_W + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cfg_we,
    input  logic [EDGE_W-1:0] cfg_edge,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [IN_W-1:0]   cfg_care,
    input  logic [IN_W-1:0]   cfg_val,
    input  logic              cfg_cnt_we,
    input  logic [CNT_W-1:0]  cfg_cnt,
    output logic              cfg_ready,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [IN_W-1:0]   q_vec,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [N_EDGE-1:0] r_mask
);

    if (IN_W != CUBE_W) begin : g_bad_in_w
        $error("IN_W must equal the cube storage width");
    end
    if (IDX_W > IDX_W_MAX || CNT_W > CNT_W_MAX) begin : g_bad_n_cube
        $error("N_CUBE exceeds the supported cube store depth");
    end

    chk_state_t        state;
    chk_state_t        state_nxt;
    cube_t             cube_mem [N_EDGE][N_CUBE];
    logic [CNT_W-1:0]  cnt [N_EDGE];
    logic [CNT_W-1:0]  cnt_wr;
    logic [CNT_W-1:0]  max_cnt;
    logic [CNT_W-1:0]  maxc;
    logic [IDX_W-1:0]  idx;
    logic [IN_W-1:0]   q_lat;
    logic [N_EDGE-1:0] acc;
    logic [N_EDGE-1:0] hit;
    logic              cfg_open;
    logic              accept;
    logic              last;
    logic              all_hit;

    assign cfg_open = (state == ST_IDLE);
    assign accept   = (state == ST_IDLE) && q_valid;
    assign last     = ({1'b0, idx} == maxc - CNT_W'(1));
    assign cnt_wr   = (cfg_cnt > CNT_W'(N_CUBE)) ? CNT_W'(N_CUBE) : cfg_cnt;

    for (genvar e = 0; e < N_EDGE; e++) begin : g_edge
        cube_t cur;
        logic  m;

        assign cur = cube_mem[e][idx];

        prm_cube_match #(.W(IN_W)) u_match (
            .q     (q_lat),
            .care  (cur.care),
            .val   (cur.val),
            .match (m)
        );

        // Edges with fewer cubes than MAXC stop contributing past their count.
        assign hit[e] = m && ({1'b0, idx} < cnt[e]);
    end

`ifdef PRM_CHK_EARLY_EXIT_EN
    logic [N_EDGE-1:0] active;

    always_comb begin
        active = '0;
        for (int e = 0; e < N_EDGE; e++) begin
            active[e] = (cnt[e] != '0);
        end
    end

    assign all_hit = (((acc | hit) & active) == active);
`else
    assign all_hit = 1'b0;
`endif

    always_comb begin
        max_cnt = '0;
        for (int e = 0; e < N_EDGE; e++) begin
            if (cnt[e] > max_cnt) begin
                max_cnt = cnt[e];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (q_valid) begin
                    state_nxt = (max_cnt == '0) ? ST_DONE : ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (last || all_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (r_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        q_ready   = 1'b0;
        cfg_ready = 1'b0;
        r_valid   = 1'b0;
        r_mask    = '0;
        case (state)
            ST_IDLE: begin
                q_ready   = 1'b1;
                cfg_ready = 1'b1;
            end
            ST_DONE: begin
                r_valid = 1'b1;
                r_mask  = acc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx   <= '0;
            maxc  <= '0;
            acc   <= '0;
            q_lat <= '0;
        end else if (accept) begin
            q_lat <= q_vec;
            maxc  <= max_cnt;
            idx   <= '0;
            acc   <= '0;
        end else if (state == ST_EVAL) begin
            acc <= acc | hit;
            idx <= (last || all_hit) ? '0 : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int e = 0; e < N_EDGE; e++) begin
                cnt[e] <= '0;
            end
        end else if (cfg_open && cfg_cnt_we) begin
            cnt[cfg_edge] <= cnt_wr;
        end
    end

    // Cube contents deliberately survive reset; only the counts are cleared.
    always_ff @(posedge CLK) begin
        if (cfg_open && cfg_we) begin
            cube_mem[cfg_edge][cfg_idx] <= '{care: cfg_care, val: cfg_val};
        end
    end

endmodule

// File: tb/tb_prm_oblgc_chk_engine.sv
// Bench for prm_oblgc_chk_engine: directed cases with literal expectations plus
// randomized configuration/query traffic checked against a behavioural model.
module tb_prm_oblgc_chk_engine;

    localparam int IN_W   = 15;
    localparam int N_EDGE = 8;
    localparam int N_CUBE = 256;
    localparam int EDGE_W = 3;
    localparam int IDX_W  = 8;
    localparam int CNT_W  = 9;

`ifdef PRM_CHK_EARLY_EXIT_EN
    localparam int EE_LAT    = 2;
    localparam bit LAT_EXACT = 1'b0;
`else
    localparam int EE_LAT    = 201;
    localparam bit LAT_EXACT = 1'b1;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              cfg_we = 1'b0;
    logic [EDGE_W-1:0] cfg_edge = '0;
    logic [IDX_W-1:0]  cfg_idx = '0;
    logic [IN_W-1:0]   cfg_care = '0;
    logic [IN_W-1:0]   cfg_val = '0;
    logic              cfg_cnt_we = 1'b0;
    logic [CNT_W-1:0]  cfg_cnt = '0;
    logic              cfg_ready;
    logic              q_valid = 1'b0;
    logic              q_ready;
    logic [IN_W-1:0]   q_vec = '0;
    logic              r_valid;
    logic              r_ready = 1'b0;
    logic [N_EDGE-1:0] r_mask;

    prm_oblgc_chk_engine #(.IN_W(IN_W), .N_EDGE(N_EDGE), .N_CUBE(N_CUBE)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cfg_we     (cfg_we),
        .cfg_edge   (cfg_edge),
        .cfg_idx    (cfg_idx),
        .cfg_care   (cfg_care),
        .cfg_val    (cfg_val),
        .cfg_cnt_we (cfg_cnt_we),
        .cfg_cnt    (cfg_cnt),
        .cfg_ready  (cfg_ready),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .q_vec      (q_vec),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_mask     (r_mask)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [IN_W-1:0] m_care [N_EDGE][N_CUBE];
    logic [IN_W-1:0] m_val  [N_EDGE][N_CUBE];
    int              m_cnt  [N_EDGE];
    bit              busy = 1'b0;
    bit              armed = 1'b0;
    int              due = 0;
    logic [7:0]      exp_mask = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Result = OR of cube matches per edge; latency from the first index at
    // which every populated edge is known blocked (early-exit build only).
    function automatic void model_eval(input logic [IN_W-1:0] q, output logic [7:0] mask,
                                       output int lat);
        int maxc;
        int first [N_EDGE];
        bit all;
        int k;
        maxc = 0;
        mask = '0;
        for (int e = 0; e < N_EDGE; e++) begin
            if (m_cnt[e] > maxc) maxc = m_cnt[e];
            first[e] = -1;
            for (int j = 0; j < m_cnt[e]; j++) begin
                if (first[e] < 0 && ((q ^ m_val[e][j]) & m_care[e][j]) == '0) first[e] = j;
            end
            mask[e] = (first[e] >= 0);
        end
        lat = maxc + 1;
        all = 1'b1;
        k = 0;
        for (int e = 0; e < N_EDGE; e++) begin
            if (m_cnt[e] > 0) begin
                if (first[e] < 0) all = 1'b0;
                else if (first[e] > k) k = first[e];
            end
        end
`ifdef PRM_CHK_EARLY_EXIT_EN
        if (maxc > 0 && all && k + 1 < maxc) lat = k + 2;
`endif
    endfunction

    always @(negedge CLK) begin
        logic [7:0] em;
        int el;
        if (armed) begin
            if (!busy) begin
                chk("q_ready_idle", 32'(q_ready), 32'd1);
                chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
                chk("r_valid_idle", 32'(r_valid), 32'd0);
            end else begin
                chk("q_ready_busy", 32'(q_ready), 32'd0);
                chk("cfg_ready_busy", 32'(cfg_ready), 32'd0);
                chk("r_valid_timing", 32'(r_valid), 32'(cyc >= due));
                if (cyc >= due) chk("r_mask_model", 32'(r_mask), 32'(exp_mask));
            end
        end
        if (RST) begin
            armed = 1'b1;
            busy  = 1'b0;
            for (int e = 0; e < N_EDGE; e++) m_cnt[e] = 0;
        end else if (!busy) begin
            if (q_valid) begin
                model_eval(q_vec, em, el);
                busy     = 1'b1;
                due      = cyc + el;
                exp_mask = em;
            end
            if (cfg_we) begin
                m_care[cfg_edge][cfg_idx] = cfg_care;
                m_val[cfg_edge][cfg_idx]  = cfg_val;
            end
            if (cfg_cnt_we) m_cnt[cfg_edge] = (int'(cfg_cnt) > N_CUBE) ? N_CUBE : int'(cfg_cnt);
        end else if (cyc >= due && r_ready) begin
            busy = 1'b0;
        end
    end

    task automatic wr_cube(input int e, input int j, input logic [IN_W-1:0] care,
                           input logic [IN_W-1:0] val);
        cfg_edge = EDGE_W'(e);
        cfg_idx  = IDX_W'(j);
        cfg_care = care;
        cfg_val  = val;
        cfg_we   = 1'b1;
        @(posedge CLK); #1;
        cfg_we = 1'b0;
    endtask

    task automatic wr_cnt(input int e, input int c);
        cfg_edge   = EDGE_W'(e);
        cfg_cnt    = CNT_W'(c);
        cfg_cnt_we = 1'b1;
        @(posedge CLK); #1;
        cfg_cnt_we = 1'b0;
    endtask

    task automatic do_accept(input logic [IN_W-1:0] q, output int t0);
        int n;
        n = 0;
        q_vec   = q;
        q_valid = 1'b1;
        @(negedge CLK);
        while (!q_ready && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (!q_ready) chk("accept_timeout", 32'(q_ready), 32'd1);
        t0 = cyc;
        @(posedge CLK); #1;
        q_valid = 1'b0;
    endtask

    task automatic wait_result(input int t0, output int lat);
        int n;
        n = 0;
        @(negedge CLK);
        while (!r_valid && n < 600) begin
            @(negedge CLK);
            n++;
        end
        if (!r_valid) chk("result_timeout", 32'(r_valid), 32'd1);
        lat = cyc - t0;
    endtask

    task automatic release_result(input int hold);
        repeat (hold) @(negedge CLK);
        @(posedge CLK); #1;
        r_ready = 1'b1;
        @(posedge CLK); #1;
        r_ready = 1'b0;
    endtask

    task automatic query_lit(input string name, input logic [IN_W-1:0] q, input bit scramble,
                             input logic [7:0] lit_mask, input int lit_lat, input bit chk_lat);
        int t0;
        int lat;
        do_accept(q, t0);
        if (scramble) q_vec = '0;
        wait_result(t0, lat);
        chk({name, "_mask"}, 32'(r_mask), 32'(lit_mask));
        if (chk_lat) chk({name, "_lat"}, 32'(lat), 32'(lit_lat));
        release_result(0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int lat;
        logic [IN_W-1:0] q;

        for (int e = 0; e < N_EDGE; e++) m_cnt[e] = 0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_q_ready", 32'(q_ready), 32'd1);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_r_mask", 32'(r_mask), 32'd0);
        @(posedge CLK); #1;

        for (int e = 0; e < N_EDGE; e++)
            for (int j = 0; j < N_CUBE; j++)
                wr_cube(e, j, IN_W'($urandom & $urandom & $urandom), IN_W'($urandom));

        query_lit("all_cnt_zero", IN_W'($urandom), 1'b0, 8'h00, 1, 1'b1);

        wr_cube(0, 0, 15'h7FFF, 15'h0001);
        wr_cnt(0, 1);
        query_lit("e0_match", 15'h0001, 1'b0, 8'h01, 2, 1'b1);
        query_lit("e0_miss", 15'h0003, 1'b0, 8'h00, 2, 1'b1);

        wr_cnt(0, 0);
        wr_cube(3, 0, 15'h7FFF, 15'h0000);
        wr_cube(3, 1, 15'h7FFF, 15'h1235);
        wr_cube(3, 2, 15'h7FFF, 15'h7FFF);
        wr_cube(3, 3, 15'h7FFF, 15'h1234);
        wr_cnt(3, 4);
        query_lit("e3_cube3", 15'h1234, 1'b1, 8'h08, 5, 1'b1);

        do_accept(15'h1234, t0);
        wait_result(t0, lat);
        chk("hold_lat", 32'(lat), 32'd5);
        @(posedge CLK); #1;
        wr_cube(3, 3, 15'h7FFF, 15'h0000);
        wr_cnt(3, 0);
        repeat (8) @(negedge CLK);
        chk("hold_mask", 32'(r_mask), 32'h08);
        chk("hold_q_ready", 32'(q_ready), 32'd0);
        release_result(0);
        query_lit("after_hold", 15'h1234, 1'b0, 8'h08, 5, 1'b1);

        wr_cnt(3, 0);
        wr_cube(5, 255, 15'h0000, 15'h0000);
        wr_cnt(5, 300);
        query_lit("cnt_clamp", IN_W'($urandom), 1'b0, 8'h20, 257, LAT_EXACT);

        wr_cnt(5, 0);
        wr_cube(0, 0, 15'h0000, 15'h0000);
        wr_cnt(0, 200);
        query_lit("early_exit", IN_W'($urandom), 1'b0, 8'h01, EE_LAT, 1'b1);

        do_accept(IN_W'($urandom), t0);
        repeat (5) @(negedge CLK);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_q_ready", 32'(q_ready), 32'd1);
        chk("midrst_r_valid", 32'(r_valid), 32'd0);
        chk("midrst_r_mask", 32'(r_mask), 32'd0);
        @(posedge CLK); #1;
        query_lit("post_rst", IN_W'($urandom), 1'b0, 8'h00, 1, 1'b1);

        for (int it = 0; it < 80; it++) begin
            int ops;
            ops = $urandom_range(0, 3);
            for (int k = 0; k < ops; k++) begin
                if ($urandom_range(0, 1) == 0)
                    wr_cube($urandom_range(0, N_EDGE - 1), $urandom_range(0, 40),
                            IN_W'($urandom & $urandom & $urandom), IN_W'($urandom));
                else
                    wr_cnt($urandom_range(0, N_EDGE - 1),
                           ($urandom_range(0, 19) == 0) ? 300 : $urandom_range(0, 40));
            end
            if ($urandom_range(0, 1) == 0) begin
                q = IN_W'($urandom);
            end else begin
                q = m_val[$urandom_range(0, N_EDGE - 1)][$urandom_range(0, 40)];
                if ($urandom_range(0, 2) == 0) q = q ^ IN_W'(1 << $urandom_range(0, IN_W - 1));
            end
            do_accept(q, t0);
            if ($urandom_range(0, 1) == 0) q_vec = IN_W'($urandom);
            wait_result(t0, lat);
            release_result($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
